ili9341_pattern_gen: RTL
========================

Name: ili9341_pattern_gen

Overview:
Parametrised frame pixel source that feeds the ILI9341 SPI controller path. It streams one WIDTH x HEIGHT frame of PIXEL_SIZE-bit RGB565 pixels per request over a valid/ready handshake. Pixel data comes from one of eight modes:
- five solid state colours (IDLE/TRISTE/CARINO/DEPRIMIDO/MUERTO);
- a checkerboard;
- colour bars;
- a coordinate gradient.

The mode is latched per frame, so a frame is never torn. The block supports backpressure and optional continuous refresh.

Parameters:
- WIDTH, 240, pixels per line; must be >= 8.
- HEIGHT, 320, lines per frame; must be >= 2.
- PIXEL_SIZE, 16, pixel word width; RGB565 constants below assume 16.
- TILE_LOG2, 3, checkerboard tile edge = 2^TILE_LOG2 pixels.
- CONTINUOUS, 0, when 1, a new frame starts automatically after each frame_done.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- mode  in  3  pattern select, sampled only at frame start
- frame_req  in  1  start one frame when idle
- pix_ready  in  1  downstream accepts pix_data this cycle
- pix_valid  out  1  pix_data holds a valid pixel
- pix_data  out  PIXEL_SIZE  current pixel
- pix_last  out  1  current pixel is (WIDTH-1, HEIGHT-1)
- pix_x  out  $clog2(WIDTH)  column of current pixel
- pix_y  out  $clog2(HEIGHT)  line of current pixel
- busy  out  1  frame in progress (state != IDLE)
- frame_done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low. rst=0 forces, without a clock edge:
    - state=IDLE;
    - pix_valid, pix_last, busy, frame_done = 0;
    - pix_data, pix_x, pix_y = 0;
    - latched mode = 0.
  - Reset mid-frame aborts the frame and does not produce frame_done.
  - All outputs are registered.
- FSM states IDLE, LOAD, STREAM:
  - IDLE, frame_req=1 at edge N: state<=LOAD and mode is latched into mode_q.
  - LOAD, edge N+1: state<=STREAM, pix_valid<=1, x=y=0, pix_data<=pixel(0,0). The first pixel is therefore valid 2 edges after the request.
  - STREAM, transfer = pix_valid && pix_ready at an edge:
    - x advances;
    - when x=WIDTH-1, x wraps to 0 and y increments;
    - pix_data, pix_last and pix_x/pix_y update to the next pixel at the same edge.
    - No transfer means every output holds stable.
  - Transfer of the pixel with pix_last=1:
    - pix_valid<=0, pix_last<=0, frame_done<=1 for one cycle;
    - if CONTINUOUS=1 or frame_req=1 at that edge, state<=LOAD, mode is re-latched, and there is a 1-cycle gap;
    - otherwise state<=IDLE.
- Requests and mode changes while busy:
  - frame_req while in LOAD or STREAM is ignored, except at the last-transfer edge as above.
  - mode changes during a frame have no effect until the next LOAD.
- Pixel function, with mode_q:
  - 0=FFE0, 1=07FF, 2=F800, 3=780F, 4=0000.
  - 5 checkerboard: ((x>>TILE_LOG2) ^ (y>>TILE_LOG2)) & 1 ? FFFF : 0000.
  - 6 colour bars:
    - BAR_W = WIDTH/8 (integer). A bar counter increments each time a line's column count within the current bar reaches BAR_W, and saturates at 7; it resets at the start of each line.
    - No divider is allowed.
    - Palette by index 0..7: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. The remainder columns use index 7.
  - 7 gradient: {x[4:0], 6'b0, y[4:0]}. Bits wrap.
- Widths: pix_x and pix_y count modulo WIDTH and HEIGHT exactly; they never reach WIDTH or HEIGHT.

Test Plan:
1. WIDTH=10, HEIGHT=10. Reset, then mode=2 and a one-cycle frame_req with pix_ready=1 held -> pix_valid rises 2 edges later; exactly 100 transfers, all F800; pix_last only on the 100th with pix_x=9, pix_y=9; frame_done high 1 cycle after it; busy falls at the same time.
2. Same config, mode=1, pix_ready pseudo-random -> pix_data, pix_x and pix_y stable whenever valid && !ready; raster order preserved; 100 transfers, all 07FF; one frame_done.
3. mode=1 at the request, switched to 4 after 50 transfers -> all 100 pixels 07FF; a second request gives 100 pixels of 0000.
4. TILE_LOG2=1, mode=5 -> (0,0)=0000, (2,0)=FFFF, (2,2)=0000, (3,1)=FFFF. Gradient mode=7 at (9,3) -> 16'h4803.
5. WIDTH=20, mode=6 -> x=0..1 give FFFF, x=12..13 give 001F, x=14..19 give 0000; the pattern repeats on every line.
6. Assert rst=0 asynchronously after 37 transfers -> all outputs 0 before the next edge and no frame_done. Release, then frame_req -> restarts at (0,0). With CONTINUOUS=1, frames repeat back-to-back, with one frame_done per 100 transfers.

Source files
------------

// File: rtl/ili9341_pattern_gen.sv
// Frame pixel source for the ILI9341 SPI path.
// Streams one WIDTH x HEIGHT frame of RGB565 pixels per request in raster order.
// Handshake: a pixel moves when pix_valid && pix_ready are both high at a rising
// clk edge; while pix_valid is high and pix_ready is low, pix_data, pix_x, pix_y
// and pix_last hold stable. pix_valid never drops without a transfer, except on reset.
module ili9341_pattern_gen #(
    parameter int WIDTH      = 240,
    parameter int HEIGHT     = 320,
    parameter int PIXEL_SIZE = 16,
    parameter int TILE_LOG2  = 3,
    parameter int CONTINUOUS = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                mode,
    input  logic                      frame_req,
    input  logic                      pix_ready,
    output logic                      pix_valid,
    output logic [PIXEL_SIZE-1:0]     pix_data,
    output logic                      pix_last,
    output logic [$clog2(WIDTH)-1:0]  pix_x,
    output logic [$clog2(HEIGHT)-1:0] pix_y,
    output logic                      busy,
    output logic                      frame_done,
    output logic [1:0]                state_dbg
);

    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT);
    localparam int BAR_W = WIDTH / 8;
    localparam int BCW   = $clog2(BAR_W + 1);

    localparam logic [XW-1:0]  X_MAX    = XW'(WIDTH - 1);
    localparam logic [YW-1:0]  Y_MAX    = YW'(HEIGHT - 1);
    localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              mode_q, mode_d;
    logic [XW-1:0]           x_q, x_d, nx;
    logic [YW-1:0]           y_q, y_d, ny;
    logic [2:0]              bar_idx_q, bar_idx_d, nbar_idx;
    logic [BCW-1:0]          bar_col_q, bar_col_d, nbar_col;
    logic                    pix_valid_q, pix_valid_d;
    logic                    pix_last_q, pix_last_d;
    logic [PIXEL_SIZE-1:0]   pix_data_q, pix_data_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;

    // Pattern colour for a coordinate; bar is the colour-bar index tracked by counters.
    function automatic logic [15:0] pixel_of(input logic [2:0] m, input logic [XW-1:0] x,
                                             input logic [YW-1:0] y, input logic [2:0] bar);
        logic [15:0] p;
        logic        tile_bit;
        tile_bit = 1'(x >> TILE_LOG2) ^ 1'(y >> TILE_LOG2);
        case (m)
            3'd0:    p = 16'hFFE0;
            3'd1:    p = 16'h07FF;
            3'd2:    p = 16'hF800;
            3'd3:    p = 16'h780F;
            3'd4:    p = 16'h0000;
            3'd5:    p = tile_bit ? 16'hFFFF : 16'h0000;
            3'd6: begin
                case (bar)
                    3'd0:    p = 16'hFFFF;
                    3'd1:    p = 16'hFFE0;
                    3'd2:    p = 16'h07FF;
                    3'd3:    p = 16'h07E0;
                    3'd4:    p = 16'hF81F;
                    3'd5:    p = 16'hF800;
                    3'd6:    p = 16'h001F;
                    default: p = 16'h0000;
                endcase
            end
            default: p = {5'(x), 6'b0, 5'(y)};
        endcase
        return p;
    endfunction

    // Raster successor of the current pixel, including the divider-free bar counters.
    always_comb begin
        nx       = x_q + XW'(1);
        ny       = y_q;
        nbar_idx = bar_idx_q;
        nbar_col = bar_col_q;
        if (x_q == X_MAX) begin
            nx       = '0;
            ny       = (y_q == Y_MAX) ? '0 : y_q + YW'(1);
            nbar_idx = '0;
            nbar_col = '0;
        end else if (bar_idx_q != 3'd7) begin
            if (bar_col_q == BAR_LAST) begin
                nbar_idx = bar_idx_q + 3'd1;
                nbar_col = '0;
            end else begin
                nbar_col = bar_col_q + BCW'(1);
            end
        end
    end

    // Frame FSM: next state and next registered outputs.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        x_d          = x_q;
        y_d          = y_q;
        bar_idx_d    = bar_idx_q;
        bar_col_d    = bar_col_q;
        pix_valid_d  = pix_valid_q;
        pix_last_d   = pix_last_q;
        pix_data_d   = pix_data_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_req) begin
                    state_d = S_LOAD;
                    mode_d  = mode;
                end
            end
            S_LOAD: begin
                state_d     = S_STREAM;
                pix_valid_d = 1'b1;
                pix_last_d  = 1'b0;
                x_d         = '0;
                y_d         = '0;
                bar_idx_d   = '0;
                bar_col_d   = '0;
                pix_data_d  = PIXEL_SIZE'(pixel_of(mode_q, '0, '0, '0));
            end
            S_STREAM: begin
                if (pix_valid_q && pix_ready) begin
                    if (pix_last_q) begin
                        pix_valid_d  = 1'b0;
                        pix_last_d   = 1'b0;
                        frame_done_d = 1'b1;
                        x_d          = '0;
                        y_d          = '0;
                        bar_idx_d    = '0;
                        bar_col_d    = '0;
                        pix_data_d   = '0;
                        if ((CONTINUOUS != 0) || frame_req) begin
                            state_d = S_LOAD;
                            mode_d  = mode;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        x_d        = nx;
                        y_d        = ny;
                        bar_idx_d  = nbar_idx;
                        bar_col_d  = nbar_col;
                        pix_last_d = (nx == X_MAX) && (ny == Y_MAX);
                        pix_data_d = PIXEL_SIZE'(pixel_of(mode_q, nx, ny, nbar_idx));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            bar_idx_q    <= '0;
            bar_col_q    <= '0;
            pix_valid_q  <= 1'b0;
            pix_last_q   <= 1'b0;
            pix_data_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            x_q          <= x_d;
            y_q          <= y_d;
            bar_idx_q    <= bar_idx_d;
            bar_col_q    <= bar_col_d;
            pix_valid_q  <= pix_valid_d;
            pix_last_q   <= pix_last_d;
            pix_data_q   <= pix_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign pix_last   = pix_last_q;
    assign pix_x      = x_q;
    assign pix_y      = y_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign state_dbg  = state_q;

endmodule
